// File: rtl/rob_param.sv
// ============================================================================
// Module   : rob_param
// Purpose  : Parameterised in-order-commit reorder buffer with operand
//            lookup and bypass, branch flush and a blocking store handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rob_param #(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int REG_W    = 5,
    parameter int WB_PORTS = 2,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rdy_in,
    input  logic                         alloc_en_in,
    input  logic [1:0]                   alloc_type_in,
    input  logic [REG_W-1:0]             alloc_dest_in,
    input  logic [ADDR_W-1:0]            alloc_pc_in,
    input  logic                         alloc_pred_in,
    input  logic [1:0]                   alloc_width_in,
    output logic                         alloc_ready_out,
    output logic [IDX_W-1:0]             alloc_tag_out,
    input  logic [WB_PORTS-1:0]          wb_en_in,
    input  logic [WB_PORTS*IDX_W-1:0]    wb_tag_in,
    input  logic [WB_PORTS*DATA_W-1:0]   wb_value_in,
    input  logic [WB_PORTS*ADDR_W-1:0]   wb_addr_in,
    input  logic [WB_PORTS-1:0]          wb_taken_in,
    input  logic [IDX_W-1:0]             qa_tag_in,
    input  logic [IDX_W-1:0]             qb_tag_in,
    output logic                         qa_ready_out,
    output logic                         qb_ready_out,
    output logic [DATA_W-1:0]            qa_value_out,
    output logic [DATA_W-1:0]            qb_value_out,
    output logic                         rf_en_out,
    output logic [REG_W-1:0]             rf_dest_out,
    output logic [DATA_W-1:0]            rf_value_out,
    output logic [IDX_W-1:0]             rf_tag_out,
    output logic                         bp_en_out,
    output logic                         bp_correct_out,
    output logic [ADDR_W-1:0]            bp_pc_out,
    output logic                         flush_out,
    output logic [ADDR_W-1:0]            flush_pc_out,
    output logic                         st_req_out,
    output logic [ADDR_W-1:0]            st_addr_out,
    output logic [DATA_W-1:0]            st_data_out,
    output logic [1:0]                   st_width_out,
    input  logic                         st_ack_in,
    output logic [IDX_W:0]               count_out
);

    localparam logic [IDX_W:0]   C_DEPTH    = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]   C_CNT_ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
    localparam logic [1:0]       C_T_BRANCH = 2'd1;
    localparam logic [1:0]       C_T_STORE  = 2'd2;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        ST_WAIT = 1'b1
    } st_state_t;

    st_state_t r_state;
    st_state_t w_state_nxt;

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_pred;
    logic [DEPTH-1:0]  r_taken;
    logic [1:0]        r_type  [DEPTH];
    logic [REG_W-1:0]  r_dest  [DEPTH];
    logic [ADDR_W-1:0] r_pc    [DEPTH];
    logic [1:0]        r_width [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];
    logic [ADDR_W-1:0] r_addr  [DEPTH];

    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W:0]    r_count;

    logic [IDX_W-1:0]  w_wb_tag   [WB_PORTS];
    logic [DATA_W-1:0] w_wb_value [WB_PORTS];
    logic [ADDR_W-1:0] w_wb_addr  [WB_PORTS];
    logic [WB_PORTS-1:0] w_wb_hit;

    logic w_head_valid;
    logic w_commit_alu;
    logic w_commit_br;
    logic w_store_start;
    logic w_store_done;
    logic w_mispredict_now;
    logic w_retire;
    logic w_alloc_fire;

    generate
        for (genvar g = 0; g < WB_PORTS; g++) begin : g_wb_unpack
            assign w_wb_tag[g]   = wb_tag_in[g*IDX_W +: IDX_W];
            assign w_wb_value[g] = wb_value_in[g*DATA_W +: DATA_W];
            assign w_wb_addr[g]  = wb_addr_in[g*ADDR_W +: ADDR_W];
            // Writebacks to idle entries, or during a stall, are dropped.
            assign w_wb_hit[g]   = rdy_in & wb_en_in[g] & r_busy[w_wb_tag[g]];
        end
    endgenerate

    assign w_head_valid = r_busy[r_head] & r_ready[r_head];

    always_comb begin
        w_state_nxt   = r_state;
        w_commit_alu  = 1'b0;
        w_commit_br   = 1'b0;
        w_store_start = 1'b0;
        w_store_done  = 1'b0;
        if (rdy_in) begin
            case (r_state)
                IDLE: begin
                    if (w_head_valid) begin
                        case (r_type[r_head])
                            C_T_BRANCH: w_commit_br = 1'b1;
                            C_T_STORE: begin
                                w_store_start = 1'b1;
                                w_state_nxt   = ST_WAIT;
                            end
                            default:    w_commit_alu = 1'b1;
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (st_ack_in) begin
                        w_store_done = 1'b1;
                        w_state_nxt  = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_mispredict_now = w_commit_br & (r_pred[r_head] != r_taken[r_head]);
    assign w_retire         = w_commit_alu | (w_commit_br & ~w_mispredict_now) | w_store_done;

    assign alloc_ready_out = (r_count < C_DEPTH) & ~w_mispredict_now;
    assign alloc_tag_out   = r_tail;
    assign w_alloc_fire    = rdy_in & alloc_en_in & alloc_ready_out;
    assign count_out       = r_count;

    always_comb begin
        qa_ready_out = r_busy[qa_tag_in] & r_ready[qa_tag_in];
        qa_value_out = r_value[qa_tag_in];
        for (int p = 0; p < WB_PORTS; p++) begin
            if (w_wb_hit[p] && (w_wb_tag[p] == qa_tag_in)) begin
                qa_ready_out = 1'b1;
                qa_value_out = w_wb_value[p];
            end
        end
    end

    always_comb begin
        qb_ready_out = r_busy[qb_tag_in] & r_ready[qb_tag_in];
        qb_value_out = r_value[qb_tag_in];
        for (int p = 0; p < WB_PORTS; p++) begin
            if (w_wb_hit[p] && (w_wb_tag[p] == qb_tag_in)) begin
                qb_ready_out = 1'b1;
                qb_value_out = w_wb_value[p];
            end
        end
    end

    // Control state, status bits and all registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= IDLE;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_busy         <= '0;
            r_ready        <= '0;
            rf_en_out      <= 1'b0;
            rf_dest_out    <= '0;
            rf_value_out   <= '0;
            rf_tag_out     <= '0;
            bp_en_out      <= 1'b0;
            bp_correct_out <= 1'b0;
            bp_pc_out      <= '0;
            flush_out      <= 1'b0;
            flush_pc_out   <= '0;
            st_req_out     <= 1'b0;
            st_addr_out    <= '0;
            st_data_out    <= '0;
            st_width_out   <= 2'd0;
        end else begin
            rf_en_out <= 1'b0;
            bp_en_out <= 1'b0;
            flush_out <= 1'b0;
            if (rdy_in) begin
                r_state <= w_state_nxt;

                for (int p = 0; p < WB_PORTS; p++) begin
                    if (w_wb_hit[p]) begin
                        r_ready[w_wb_tag[p]] <= 1'b1;
                    end
                end

                if (w_alloc_fire) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_tail          <= r_tail + C_IDX_ONE;
                end

                if (w_commit_alu) begin
                    rf_en_out    <= 1'b1;
                    rf_dest_out  <= r_dest[r_head];
                    rf_value_out <= r_value[r_head];
                    rf_tag_out   <= r_head;
                end

                if (w_commit_br) begin
                    bp_en_out      <= 1'b1;
                    bp_correct_out <= ~w_mispredict_now;
                    bp_pc_out      <= r_pc[r_head];
                end

                if (w_store_start) begin
                    st_req_out   <= 1'b1;
                    st_addr_out  <= r_addr[r_head];
                    st_data_out  <= r_value[r_head];
                    st_width_out <= r_width[r_head];
                end

                if (w_store_done) begin
                    st_req_out <= 1'b0;
                end

                if (w_retire) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + C_IDX_ONE;
                end

                case ({w_alloc_fire, w_retire})
                    2'b10:   r_count <= r_count + C_CNT_ONE;
                    2'b01:   r_count <= r_count - C_CNT_ONE;
                    default: r_count <= r_count;
                endcase

                // A mispredict discards every younger entry; it overrides the updates above.
                if (w_mispredict_now) begin
                    flush_out    <= 1'b1;
                    flush_pc_out <= r_addr[r_head];
                    r_busy       <= '0;
                    r_head       <= '0;
                    r_tail       <= '0;
                    r_count      <= '0;
                end
            end
        end
    end

    // Entry payload needs no reset: it is only read while the busy bit is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            for (int p = 0; p < WB_PORTS; p++) begin
                if (w_wb_hit[p]) begin
                    r_value[w_wb_tag[p]] <= w_wb_value[p];
                    r_addr[w_wb_tag[p]]  <= w_wb_addr[p];
                    r_taken[w_wb_tag[p]] <= wb_taken_in[p];
                end
            end
            if (w_alloc_fire) begin
                r_type[r_tail]  <= alloc_type_in;
                r_dest[r_tail]  <= alloc_dest_in;
                r_pc[r_tail]    <= alloc_pc_in;
                r_pred[r_tail]  <= alloc_pred_in;
                r_width[r_tail] <= alloc_width_in;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rob_param.sv
// ============================================================================
// Module   : tb_rob_param
// Purpose  : Self-checking bench for rob_param: queue-based reference model
//            compared every cycle, plus directed scenarios with literal values.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rob_param;

    localparam int DEPTH = 16;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int RW    = 5;
    localparam int NP    = 2;
    localparam int IW    = 4;

    logic            clk_in = 1'b0;
    logic            rst_n_in;
    logic            rdy_in;
    logic            alloc_en_in;
    logic [1:0]      alloc_type_in;
    logic [RW-1:0]   alloc_dest_in;
    logic [AW-1:0]   alloc_pc_in;
    logic            alloc_pred_in;
    logic [1:0]      alloc_width_in;
    logic            alloc_ready_out;
    logic [IW-1:0]   alloc_tag_out;
    logic [NP-1:0]   wb_en_in;
    logic [NP*IW-1:0] wb_tag_in;
    logic [NP*DW-1:0] wb_value_in;
    logic [NP*AW-1:0] wb_addr_in;
    logic [NP-1:0]   wb_taken_in;
    logic [IW-1:0]   qa_tag_in, qb_tag_in;
    logic            qa_ready_out, qb_ready_out;
    logic [DW-1:0]   qa_value_out, qb_value_out;
    logic            rf_en_out;
    logic [RW-1:0]   rf_dest_out;
    logic [DW-1:0]   rf_value_out;
    logic [IW-1:0]   rf_tag_out;
    logic            bp_en_out, bp_correct_out;
    logic [AW-1:0]   bp_pc_out;
    logic            flush_out;
    logic [AW-1:0]   flush_pc_out;
    logic            st_req_out;
    logic [AW-1:0]   st_addr_out;
    logic [DW-1:0]   st_data_out;
    logic [1:0]      st_width_out;
    logic            st_ack_in;
    logic [IW:0]     count_out;

    rob_param #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW), .REG_W(RW), .WB_PORTS(NP)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .alloc_en_in(alloc_en_in), .alloc_type_in(alloc_type_in), .alloc_dest_in(alloc_dest_in),
        .alloc_pc_in(alloc_pc_in), .alloc_pred_in(alloc_pred_in), .alloc_width_in(alloc_width_in),
        .alloc_ready_out(alloc_ready_out), .alloc_tag_out(alloc_tag_out),
        .wb_en_in(wb_en_in), .wb_tag_in(wb_tag_in), .wb_value_in(wb_value_in),
        .wb_addr_in(wb_addr_in), .wb_taken_in(wb_taken_in),
        .qa_tag_in(qa_tag_in), .qb_tag_in(qb_tag_in),
        .qa_ready_out(qa_ready_out), .qb_ready_out(qb_ready_out),
        .qa_value_out(qa_value_out), .qb_value_out(qb_value_out),
        .rf_en_out(rf_en_out), .rf_dest_out(rf_dest_out), .rf_value_out(rf_value_out),
        .rf_tag_out(rf_tag_out), .bp_en_out(bp_en_out), .bp_correct_out(bp_correct_out),
        .bp_pc_out(bp_pc_out), .flush_out(flush_out), .flush_pc_out(flush_pc_out),
        .st_req_out(st_req_out), .st_addr_out(st_addr_out), .st_data_out(st_data_out),
        .st_width_out(st_width_out), .st_ack_in(st_ack_in), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: program-order queue ----------------
    typedef struct {
        logic [IW-1:0] tag;
        logic [1:0]    typ;
        logic [RW-1:0] dest;
        logic [AW-1:0] pc;
        logic          pred;
        logic [1:0]    width;
        logic          rdy;
        logic [DW-1:0] value;
        logic [AW-1:0] addr;
        logic          taken;
    } ent_t;

    ent_t          q[$];
    int            m_tail;
    bit            m_wait;
    logic          e_rf_en, e_bp_en, e_bp_ok, e_flush, e_st_req;
    logic [RW-1:0] e_rf_dest;
    logic [DW-1:0] e_rf_value, e_st_data;
    logic [IW-1:0] e_rf_tag;
    logic [AW-1:0] e_bp_pc, e_flush_pc, e_st_addr;
    logic [1:0]    e_st_width;

    task automatic model_reset();
        q.delete();
        m_tail = 0; m_wait = 0;
        e_rf_en = 0; e_bp_en = 0; e_bp_ok = 0; e_flush = 0; e_st_req = 0;
        e_rf_dest = 0; e_rf_value = 0; e_rf_tag = 0; e_bp_pc = 0; e_flush_pc = 0;
        e_st_addr = 0; e_st_data = 0; e_st_width = 0;
    endtask

    function automatic bit model_misp_now();
        return rdy_in && !m_wait && q.size() > 0 && q[0].rdy &&
               q[0].typ == 2'd1 && q[0].pred != q[0].taken;
    endfunction

    task automatic model_lookup(input logic [IW-1:0] t, output logic r, output logic [DW-1:0] v);
        r = 0; v = 0;
        foreach (q[j]) if (q[j].tag == t) begin r = q[j].rdy; v = q[j].value; end
        for (int p = 0; p < NP; p++) begin
            if (rdy_in && wb_en_in[p] && wb_tag_in[p*IW +: IW] == t) begin
                foreach (q[j]) if (q[j].tag == t) begin r = 1; v = wb_value_in[p*DW +: DW]; end
            end
        end
    endtask

    task automatic model_step();
        bit do_alu, do_br, do_st, do_ack, misp, acc;
        ent_t h;
        e_rf_en = 0; e_bp_en = 0; e_flush = 0;
        if (!rdy_in) return;
        do_alu = 0; do_br = 0; do_st = 0; do_ack = 0;
        if (!m_wait && q.size() > 0 && q[0].rdy) begin
            h = q[0];
            if (h.typ == 2'd1) do_br = 1;
            else if (h.typ == 2'd2) do_st = 1;
            else do_alu = 1;
        end else if (m_wait && st_ack_in) begin
            do_ack = 1;
        end
        misp = model_misp_now();
        acc  = alloc_en_in && q.size() < DEPTH && !misp;
        for (int p = 0; p < NP; p++) begin
            if (wb_en_in[p]) begin
                foreach (q[j]) if (q[j].tag == wb_tag_in[p*IW +: IW]) begin
                    q[j].rdy   = 1;
                    q[j].value = wb_value_in[p*DW +: DW];
                    q[j].addr  = wb_addr_in[p*AW +: AW];
                    q[j].taken = wb_taken_in[p];
                end
            end
        end
        if (do_alu) begin
            e_rf_en = 1; e_rf_dest = h.dest; e_rf_value = h.value; e_rf_tag = h.tag;
            void'(q.pop_front());
        end
        if (do_br) begin
            e_bp_en = 1; e_bp_ok = (h.pred == h.taken); e_bp_pc = h.pc;
            if (misp) begin
                e_flush = 1; e_flush_pc = h.addr;
                q.delete(); m_tail = 0;
            end else begin
                void'(q.pop_front());
            end
        end
        if (do_st) begin
            m_wait = 1; e_st_req = 1;
            e_st_addr = h.addr; e_st_data = h.value; e_st_width = h.width;
        end
        if (do_ack) begin
            m_wait = 0; e_st_req = 0;
            void'(q.pop_front());
        end
        if (acc) begin
            ent_t n;
            n.tag = IW'(m_tail); n.typ = alloc_type_in; n.dest = alloc_dest_in;
            n.pc = alloc_pc_in; n.pred = alloc_pred_in; n.width = alloc_width_in;
            n.rdy = 0; n.value = 0; n.addr = 0; n.taken = 0;
            q.push_back(n);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    task automatic model_compare();
        logic r; logic [DW-1:0] v;
        chk("alloc_ready", alloc_ready_out, q.size() < DEPTH && !model_misp_now());
        chk("alloc_tag", alloc_tag_out, m_tail);
        chk("count", count_out, q.size());
        model_lookup(qa_tag_in, r, v);
        chk("qa_ready", qa_ready_out, r);
        if (r) chk("qa_value", qa_value_out, v);
        model_lookup(qb_tag_in, r, v);
        chk("qb_ready", qb_ready_out, r);
        if (r) chk("qb_value", qb_value_out, v);
        chk("rf_en", rf_en_out, e_rf_en);
        if (e_rf_en) begin
            chk("rf_dest", rf_dest_out, e_rf_dest);
            chk("rf_value", rf_value_out, e_rf_value);
            chk("rf_tag", rf_tag_out, e_rf_tag);
        end
        chk("bp_en", bp_en_out, e_bp_en);
        if (e_bp_en) begin
            chk("bp_correct", bp_correct_out, e_bp_ok);
            chk("bp_pc", bp_pc_out, e_bp_pc);
        end
        chk("flush", flush_out, e_flush);
        if (e_flush) chk("flush_pc", flush_pc_out, e_flush_pc);
        chk("st_req", st_req_out, e_st_req);
        if (e_st_req) begin
            chk("st_addr", st_addr_out, e_st_addr);
            chk("st_data", st_data_out, e_st_data);
            chk("st_width", st_width_out, e_st_width);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk_in);
            if (!rst_n_in) model_reset();
            model_compare();
            @(posedge clk_in);
            if (!rst_n_in) model_reset();
            else model_step();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] log_q[$];

    task automatic tick();
        @(posedge clk_in);
        #2;
        if (rf_en_out) log_q.push_back(rf_value_out);
    endtask

    task automatic idle_inputs();
        rdy_in = 1; alloc_en_in = 0; alloc_type_in = 0; alloc_dest_in = 0;
        alloc_pc_in = 0; alloc_pred_in = 0; alloc_width_in = 0;
        wb_en_in = 0; wb_tag_in = 0; wb_value_in = 0; wb_addr_in = 0; wb_taken_in = 0;
        qa_tag_in = 0; qb_tag_in = 0; st_ack_in = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n_in = 0;
        tick(); tick();
        rst_n_in = 1;
        log_q.delete();
    endtask

    task automatic set_alloc(input logic [1:0] t, input int dest, input logic [AW-1:0] pc,
                             input logic pred, input logic [1:0] w);
        alloc_en_in = 1; alloc_type_in = t; alloc_dest_in = RW'(dest);
        alloc_pc_in = pc; alloc_pred_in = pred; alloc_width_in = w;
    endtask

    task automatic set_wb(input int ch, input int tag, input logic [DW-1:0] v,
                          input logic [AW-1:0] a, input logic tk);
        wb_en_in[ch] = 1;
        wb_tag_in[ch*IW +: IW] = IW'(tag);
        wb_value_in[ch*DW +: DW] = v;
        wb_addr_in[ch*AW +: AW] = a;
        wb_taken_in[ch] = tk;
    endtask

    initial begin
        bit got, seen4;
        int exp_tags[4];
        int prev_tag;
        exp_tags = '{14, 15, 0, 1};
        idle_inputs();
        rst_n_in = 0;
        repeat (3) tick();
        chk("rst_count", count_out, 0);
        chk("rst_st_req", st_req_out, 0);
        chk("rst_rf_en", rf_en_out, 0);
        chk("rst_flush", flush_out, 0);
        rst_n_in = 1;

        // Fill completely, then one writeback frees the head while a 17th waits.
        for (int i = 0; i < 16; i++) begin
            set_alloc(2'd0, i + 1, 32'h100 + 4 * i, 0, 0);
            tick();
        end
        alloc_en_in = 0;
        chk("full_ready", alloc_ready_out, 0);
        chk("full_count", count_out, 16);
        set_wb(0, 0, 32'h55, 0, 0);
        set_alloc(2'd0, 17, 32'h200, 0, 0);
        tick();
        wb_en_in = 0;
        tick();
        chk("full_rf_en", rf_en_out, 1);
        chk("full_rf_value", rf_value_out, 32'h55);
        chk("full_rf_tag", rf_tag_out, 0);
        chk("full_ready_after", alloc_ready_out, 1);
        tick();
        alloc_en_in = 0;
        chk("full_count_after", count_out, 16);

        // Mispredicted branch at tag 3 discards tags 4 and 5.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_alloc(i == 3 ? 2'd1 : 2'd0, i, 32'h1000 + 4 * (i - 3), i == 3, 0);
            tick();
        end
        alloc_en_in = 0;
        for (int i = 0; i < 3; i++) begin
            set_wb(0, i, 32'h10 + i, 0, 0);
            tick();
        end
        set_wb(0, 3, 0, 32'h1004, 0);
        set_wb(1, 4, 32'h44, 0, 0);
        tick();
        wb_en_in = 0;
        got = 0; seen4 = 0;
        for (int k = 0; k < 12; k++) begin
            if (rf_en_out && rf_tag_out == 4) seen4 = 1;
            if (flush_out && !got) begin
                got = 1;
                chk("misp_flush_pc", flush_pc_out, 32'h1004);
                chk("misp_bp_en", bp_en_out, 1);
                chk("misp_bp_correct", bp_correct_out, 0);
                chk("misp_bp_pc", bp_pc_out, 32'h1000);
                chk("misp_count", count_out, 0);
            end
            tick();
        end
        chk("misp_flush_seen", got, 1);
        chk("misp_tag4_never", seen4, 0);

        // Store blocks commit until acknowledged.
        do_reset();
        set_alloc(2'd2, 0, 32'h300, 0, 2'd0);
        tick();
        set_alloc(2'd0, 9, 32'h304, 0, 0);
        tick();
        alloc_en_in = 0;
        set_wb(0, 0, 32'hAB, 32'h20, 0);
        set_wb(1, 1, 32'h77, 0, 0);
        tick();
        wb_en_in = 0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("st_req_hold", st_req_out, 1);
            chk("st_addr_hold", st_addr_out, 32'h20);
            chk("st_data_hold", st_data_out, 32'hAB);
            chk("st_width_hold", st_width_out, 0);
            chk("st_no_commit", rf_en_out, 0);
            tick();
        end
        st_ack_in = 1;
        tick();
        st_ack_in = 0;
        chk("st_req_drop", st_req_out, 0);
        chk("st_count_after_ack", count_out, 1);
        chk("st_no_commit_ack", rf_en_out, 0);
        tick();
        chk("st_alu_rf_en", rf_en_out, 1);
        chk("st_alu_tag", rf_tag_out, 1);
        chk("st_alu_value", rf_value_out, 32'h77);

        // Two channels hit the same tag; channel 1 wins, visible via bypass.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(2'd0, i, 32'h400 + 4 * i, 0, 0);
            tick();
        end
        alloc_en_in = 0;
        set_wb(0, 2, 32'd7, 0, 0);
        set_wb(1, 2, 32'd9, 0, 0);
        qa_tag_in = 2;
        #1;
        chk("byp_qa_ready", qa_ready_out, 1);
        chk("byp_qa_value", qa_value_out, 9);
        tick();
        wb_en_in = 0;
        set_wb(0, 0, 32'd1, 0, 0);
        set_wb(1, 1, 32'd2, 0, 0);
        tick();
        wb_en_in = 0;
        repeat (6) tick();
        chk("byp_commits", log_q.size(), 3);
        if (log_q.size() == 3) chk("byp_commit_value", log_q[2], 9);

        // Twenty allocations with trailing commits walk the pointers across the wrap.
        do_reset();
        prev_tag = 0;
        for (int i = 0; i < 20; i++) begin
            set_alloc(2'd0, i, 32'h500 + 4 * i, 0, 0);
            if (i > 0) set_wb(0, prev_tag, 100 + i - 1, 0, 0);
            if (i >= 14 && i <= 17) chk("wrap_tag", alloc_tag_out, exp_tags[i-14]);
            prev_tag = alloc_tag_out;
            tick();
            wb_en_in = 0;
        end
        alloc_en_in = 0;
        set_wb(0, prev_tag, 119, 0, 0);
        tick();
        wb_en_in = 0;
        repeat (4) tick();
        chk("wrap_commits", log_q.size(), 20);
        for (int k = 0; k < 20 && k < log_q.size(); k++) chk("wrap_order", log_q[k], 100 + k);

        // Asynchronous reset in the middle of a store handshake.
        do_reset();
        set_alloc(2'd2, 0, 32'h600, 0, 2'd2);
        tick();
        alloc_en_in = 0;
        set_wb(0, 0, 32'hCD, 32'h40, 0);
        tick();
        wb_en_in = 0;
        tick();
        chk("arst_st_req_before", st_req_out, 1);
        #1 rst_n_in = 0;
        #1;
        chk("arst_st_req", st_req_out, 0);
        chk("arst_count", count_out, 0);
        chk("arst_st_addr", st_addr_out, 0);
        tick();
        rst_n_in = 1;
        st_ack_in = 1;
        tick();
        st_ack_in = 0;
        chk("arst_late_ack_req", st_req_out, 0);
        chk("arst_late_ack_count", count_out, 0);
        tick();
        chk("arst_late_ack_rf", rf_en_out, 0);

        // Randomised traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rdy_in = ($urandom_range(0, 7) != 0);
            alloc_en_in = $urandom_range(0, 1);
            alloc_type_in = 2'($urandom_range(0, 3));
            alloc_dest_in = RW'($urandom);
            alloc_pc_in = $urandom;
            alloc_pred_in = $urandom_range(0, 1);
            alloc_width_in = 2'($urandom_range(0, 2));
            for (int p = 0; p < NP; p++) begin
                int t;
                wb_en_in[p] = ($urandom_range(0, 2) != 0);
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    t = q[$urandom_range(0, q.size() - 1)].tag;
                else
                    t = $urandom_range(0, DEPTH - 1);
                wb_tag_in[p*IW +: IW] = IW'(t);
                wb_value_in[p*DW +: DW] = $urandom;
                wb_addr_in[p*AW +: AW] = $urandom;
                wb_taken_in[p] = $urandom_range(0, 1);
            end
            qa_tag_in = IW'($urandom);
            qb_tag_in = IW'($urandom);
            st_ack_in = ($urandom_range(0, 2) == 0);
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
